// File: rtl/vga_pkg.sv
// Shared VGA raster constants and score-digit helpers for the timing block and the pixel generator.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package vga_pkg;

   // 640x480@60 Hz raster, counted in pixel ticks
   localparam int H_VISIBLE = 640;
   localparam int H_FP      = 16;
   localparam int H_SYNC    = 96;
   localparam int H_BP      = 48;
   localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;   // 800

   localparam int V_VISIBLE = 480;
   localparam int V_FP      = 10;
   localparam int V_SYNC    = 2;
   localparam int V_BP      = 33;
   localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;   // 525

   // 100 MHz system clock down to a 25 MHz pixel tick
   localparam int CLK_DIV = 4;

   // Sync pulse level; 0 means the pulses are active-low
   localparam logic SYNC_ACTIVE = 1'b0;

   // Score digits are single decimal digits
   localparam int SCORE_W   = 4;
   localparam int SCORE_MAX = 9;

   // Saturate a requested digit at the largest displayable value
   function automatic logic [SCORE_W-1:0] sat_digit(input logic [SCORE_W-1:0] d,
                                                    input logic [SCORE_W-1:0] lim);
      return (d > lim) ? lim : d;
   endfunction

endpackage

// File: rtl/vga_clk_en.sv
// Pixel-tick generator: one-clock enable pulse every DIV_RATIO system clocks.
// Latency: first pulse DIV_RATIO clocks after reset release, registered output.
// Backpressure: none; free-running.
module vga_clk_en
   import vga_pkg::*;
#(
   parameter int DIV_RATIO = CLK_DIV
) (
   input  logic clk_i,
   input  logic rst_n_i,
   output logic pix_en_o
);

   localparam int               DIV_W    = (DIV_RATIO > 2) ? $clog2(DIV_RATIO) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_RATIO - 1);

   logic [DIV_W-1:0] div_q, div_d;
   logic             pix_en_q, pix_en_d;

   // Wrap the divider and flag the clock that follows its last count
   always_comb begin
      div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      pix_en_d = (div_q == DIV_LAST);
   end

   // Divider state and registered pixel tick
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         div_q    <= '0;
         pix_en_q <= 1'b0;
      end else begin
         div_q    <= div_d;
         pix_en_q <= pix_en_d;
      end
   end

   assign pix_en_o = pix_en_q;

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster timing (pixel tick, h/v counters, syncs, visible flag) plus frame-synchronous score digits.
// Latency: decoded outputs align with h_cnt/v_cnt; scores commit at the frame_end clock edge.
// Backpressure: none; free-running raster, score_load is a fire-and-forget strobe.
module vga_timing_ctrl #(
   parameter int   H_VISIBLE   = vga_pkg::H_VISIBLE,
   parameter int   H_FP        = vga_pkg::H_FP,
   parameter int   H_SYNC      = vga_pkg::H_SYNC,
   parameter int   H_BP        = vga_pkg::H_BP,
   parameter int   V_VISIBLE   = vga_pkg::V_VISIBLE,
   parameter int   V_FP        = vga_pkg::V_FP,
   parameter int   V_SYNC      = vga_pkg::V_SYNC,
   parameter int   V_BP        = vga_pkg::V_BP,
   parameter int   CLK_DIV     = vga_pkg::CLK_DIV,
   parameter logic SYNC_ACTIVE = vga_pkg::SYNC_ACTIVE,
   parameter int   SCORE_MAX   = vga_pkg::SCORE_MAX
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] score0_in,
   input  logic [3:0] score1_in,
   input  logic       score_load,
   output logic       pix_en,
   output logic [9:0] h_cnt,
   output logic [9:0] v_cnt,
   output logic       valid,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_end,
   output logic [3:0] score0,
   output logic [3:0] score1
);
   import vga_pkg::*;

   localparam int                 LINE_LEN    = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int                 FRAME_LINES = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam logic [SCORE_W-1:0] SMAX        = SCORE_W'(SCORE_MAX);

   logic [9:0]         h_q, h_d, v_q, v_d;
   logic               valid_q, valid_d, hsync_q, hsync_d, vsync_q, vsync_d;
   logic               in_hs, in_vs;
   logic [SCORE_W-1:0] stage0_q, stage0_d, stage1_q, stage1_d;
   logic [SCORE_W-1:0] score0_q, score0_d, score1_q, score1_d;
   logic [SCORE_W-1:0] ld0, ld1;
   logic               pending_q, pending_d;

   vga_clk_en #(
      .DIV_RATIO (CLK_DIV)
   ) u_clk_en (
      .clk_i    (clk),
      .rst_n_i  (rst_n),
      .pix_en_o (pix_en)
   );

   // Next raster position and the sync/visible decode of that position
   always_comb begin
      h_d = h_q;
      v_d = v_q;
      if (pix_en) begin
         if (h_q == 10'(LINE_LEN - 1)) begin
            h_d = '0;
            v_d = (v_q == 10'(FRAME_LINES - 1)) ? '0 : v_q + 10'd1;
         end else begin
            h_d = h_q + 10'd1;
         end
      end
      in_hs   = (h_d >= 10'(H_VISIBLE + H_FP)) && (h_d < 10'(H_VISIBLE + H_FP + H_SYNC));
      in_vs   = (v_d >= 10'(V_VISIBLE + V_FP)) && (v_d < 10'(V_VISIBLE + V_FP + V_SYNC));
      valid_d = (h_d < 10'(H_VISIBLE)) && (v_d < 10'(V_VISIBLE));
      hsync_d = in_hs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vsync_d = in_vs ? SYNC_ACTIVE : ~SYNC_ACTIVE;
   end

   // Counters and decoded outputs move together, only on pixel ticks, so the
   // reset-time (0,0) keeps valid low until the first tick
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q     <= '0;
         v_q     <= '0;
         valid_q <= 1'b0;
         hsync_q <= ~SYNC_ACTIVE;
         vsync_q <= ~SYNC_ACTIVE;
      end else if (pix_en) begin
         h_q     <= h_d;
         v_q     <= v_d;
         valid_q <= valid_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
      end
   end

   // Entry into vertical blank: the tick that moves the raster to (0, V_VISIBLE)
   assign frame_end = pix_en && (h_q == 10'(LINE_LEN - 1)) && (v_q == 10'(V_VISIBLE - 1));

   assign ld0 = sat_digit(score0_in, SMAX);
   assign ld1 = sat_digit(score1_in, SMAX);

   // Stage loads mid-frame; commit at frame_end, where a coincident load wins outright
   always_comb begin
      stage0_d  = stage0_q;
      stage1_d  = stage1_q;
      score0_d  = score0_q;
      score1_d  = score1_q;
      pending_d = pending_q;
      if (frame_end) begin
         if (score_load) begin
            score0_d  = ld0;
            score1_d  = ld1;
            pending_d = 1'b0;
         end else if (pending_q) begin
            score0_d  = stage0_q;
            score1_d  = stage1_q;
            pending_d = 1'b0;
         end
      end else if (score_load) begin
         stage0_d  = ld0;
         stage1_d  = ld1;
         pending_d = 1'b1;
      end
   end

   // Score shadow registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage0_q  <= '0;
         stage1_q  <= '0;
         score0_q  <= '0;
         score1_q  <= '0;
         pending_q <= 1'b0;
      end else begin
         stage0_q  <= stage0_d;
         stage1_q  <= stage1_d;
         score0_q  <= score0_d;
         score1_q  <= score1_d;
         pending_q <= pending_d;
      end
   end

   assign h_cnt  = h_q;
   assign v_cnt  = v_q;
   assign valid  = valid_q;
   assign hsync  = hsync_q;
   assign vsync  = vsync_q;
   assign score0 = score0_q;
   assign score1 = score1_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl on a shrunken raster (16x12 ticks) so several frames fit in a short run.
// Expected per-tick observations are queued ahead of each pixel tick and checked by a monitor.
// Score loads, same-clock load/frame_end and mid-frame async reset are driven from a directed table.
module tb_vga_timing_ctrl;

   // Shrunken raster: h 0..15 (visible 0..7, hsync 10..12), v 0..11 (visible 0..5, vsync 8..9)
   localparam int HV = 8, HF = 2, HS = 3, HB = 3;
   localparam int VV = 6, VF = 2, VS = 2, VB = 2;
   localparam int HT = 16, FRAME = 192;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] score0_in, score1_in;
   logic       score_load;
   logic       pix_en, valid, hsync, vsync, frame_end;
   logic [9:0] h_cnt, v_cnt;
   logic [3:0] score0, score1;

   always #5 clk = ~clk;

   vga_timing_ctrl #(
      .H_VISIBLE (HV), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
      .V_VISIBLE (VV), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
      .CLK_DIV (4), .SYNC_ACTIVE (1'b0), .SCORE_MAX (9)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .score0_in (score0_in), .score1_in (score1_in), .score_load (score_load),
      .pix_en (pix_en), .h_cnt (h_cnt), .v_cnt (v_cnt), .valid (valid),
      .hsync (hsync), .vsync (vsync), .frame_end (frame_end),
      .score0 (score0), .score1 (score1)
   );

   typedef struct {
      int   ph;
      int   t;
      int   h;
      int   v;
      logic vld;
      logic hs;
      logic vs;
      logic fe;
      int   s0;
      int   s1;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   checks = 0;
   int   errors = 0;
   int   valid_f1 = 0, hs_low_f1 = 0, vs_low_f1 = 0;

   // Directed score loads: tick, right digit, left digit (tick 479 is a frame_end tick)
   int ld_t[5] = '{40, 212, 242, 479, 676};
   int ld_a[5] = '{7, 1, 5, 4, 8};
   int ld_b[5] = '{3, 1, 12, 2, 8};

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Hand-computed committed scores per tick of the run
   task automatic exp_scores(input int ph, input int t, output int s0, output int s1);
      if (ph != 0 || t < 96) begin s0 = 0; s1 = 0; end
      else if (t < 288)     begin s0 = 7; s1 = 3; end
      else if (t < 480)     begin s0 = 5; s1 = 9; end
      else                  begin s0 = 4; s1 = 2; end
   endtask

   task automatic push_exp(input int ph, input int t);
      exp_t x;
      int   p;
      p     = t % FRAME;
      x.ph  = ph;
      x.t   = t;
      x.h   = p % HT;
      x.v   = p / HT;
      x.vld = (t > 0) && (x.h < HV) && (x.v < VV);
      x.hs  = !((x.h >= 10) && (x.h <= 12));
      x.vs  = !((x.v >= 8) && (x.v <= 9));
      x.fe  = (x.h == 15) && (x.v == 5);
      exp_scores(ph, t, x.s0, x.s1);
      exp_q.push_back(x);
   endtask

   // Wait for the next pixel-tick cycle; returns the number of clocks it took
   task automatic wait_tick(output int clks);
      clks = 0;
      do begin
         @(posedge clk);
         #1;
         score_load = 1'b0;
         clks++;
      end while (!pix_en && clks < 16);
   endtask

   task automatic run_ticks(input int ph, input int n);
      int clks;
      for (int t = 0; t < n; t++) begin
         push_exp(ph, t);
         wait_tick(clks);
         chk((t == 0) ? "first_pix_en_clk" : "pix_en_period", clks, 4);
         if (ph == 0) begin
            for (int k = 0; k < 5; k++) begin
               if (ld_t[k] == t) begin
                  score0_in  = 4'(ld_a[k]);
                  score1_in  = 4'(ld_b[k]);
                  score_load = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_pix_en"},    int'(pix_en), 0);
      chk({tag, "_h_cnt"},     int'(h_cnt), 0);
      chk({tag, "_v_cnt"},     int'(v_cnt), 0);
      chk({tag, "_valid"},     int'(valid), 0);
      chk({tag, "_hsync"},     int'(hsync), 1);
      chk({tag, "_vsync"},     int'(vsync), 1);
      chk({tag, "_frame_end"}, int'(frame_end), 0);
      chk({tag, "_score0"},    int'(score0), 0);
      chk({tag, "_score1"},    int'(score1), 0);
   endtask

   // Monitor: every pixel tick pops one expectation; frame_end must stay low between ticks
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (pix_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL tick_unexpected: pixel tick with no expectation at h=%0d v=%0d", h_cnt, v_cnt);
            end else begin
               e = exp_q.pop_front();
               if (int'(h_cnt) != e.h || int'(v_cnt) != e.v || valid !== e.vld || hsync !== e.hs ||
                   vsync !== e.vs || frame_end !== e.fe || int'(score0) != e.s0 || int'(score1) != e.s1) begin
                  errors++;
                  $display("FAIL tick ph=%0d t=%0d: got h=%0d v=%0d valid=%b hs=%b vs=%b fe=%b s0=%0d s1=%0d, expected h=%0d v=%0d valid=%b hs=%b vs=%b fe=%b s0=%0d s1=%0d",
                           e.ph, e.t, h_cnt, v_cnt, valid, hsync, vsync, frame_end, score0, score1,
                           e.h, e.v, e.vld, e.hs, e.vs, e.fe, e.s0, e.s1);
               end
               if (e.ph == 0 && e.t >= FRAME && e.t < 2 * FRAME) begin
                  if (valid === 1'b1) valid_f1++;
                  if (hsync === 1'b0) hs_low_f1++;
                  if (vsync === 1'b0) vs_low_f1++;
               end
            end
         end else begin
            checks++;
            if (frame_end !== 1'b0) begin
               errors++;
               $display("FAIL frame_end_off_tick: got %b, expected 0", frame_end);
            end
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n      = 1'b0;
      score0_in  = '0;
      score1_in  = '0;
      score_load = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_state("por");

      @(negedge clk);
      rst_n = 1'b1;
      // Ticks 0..821: three full frames plus part of a fourth, ending at h=5 v=3 with 8,8 pending
      run_ticks(0, 822);

      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_reset_state("async_rst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      // Restart from power-up state; the discarded 8,8 must never appear
      run_ticks(1, 130);

      @(negedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      chk("frame1_valid_ticks", valid_f1, 48);
      chk("frame1_hsync_low_ticks", hs_low_f1, 36);
      chk("frame1_vsync_low_ticks", vs_low_f1, 32);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
